// File: rtl/mem_port_arbiter.sv
// Single-ported data memory arbiter: store commits vs. load issue, with a
// load-starvation guard and an in-order in-flight load tag FIFO.
module mem_port_arbiter #(
  parameter int unsigned MAX_INFLIGHT     = 4,
  parameter int unsigned STORE_STREAK_MAX = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        ld_req_valid,
  output logic        ld_req_ready,
  input  logic [31:0] ld_req_addr,
  input  logic [2:0]  ld_req_func3,
  input  logic [4:0]  ld_req_rob,
  input  logic [6:0]  ld_req_pd,
  input  logic        st_req_valid,
  output logic        st_req_ready,
  input  logic [31:0] st_req_addr,
  input  logic [31:0] st_req_data,
  input  logic        st_req_sh,
  output logic        mem_req_valid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        ld_resp_valid,
  output logic [31:0] ld_resp_data,
  output logic [6:0]  ld_resp_pd,
  output logic [4:0]  ld_resp_rob,
  output logic        err_spurious
);

  localparam int unsigned PTR_W = $clog2(MAX_INFLIGHT);
  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam int unsigned STK_W = $clog2(STORE_STREAK_MAX + 1);

  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_LBU  = 3'b100;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef struct packed {
    logic [4:0] rob;
    logic [6:0] pd;
    logic       squash;
  } tag_t;

  tag_t             fifo_q [MAX_INFLIGHT];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [STK_W-1:0] streak_q;

  logic full_c;
  logic f3_ok_c;
  logic ld_ok_c;
  logic force_ld_c;
  logic st_gnt_c;
  logic ld_gnt_c;
  logic pop_c;
  logic squash_pop_c;

  // Grant decision; nothing is granted while reset is asserted
  always_comb begin
    full_c     = (count_q == CNT_W'(MAX_INFLIGHT));
    f3_ok_c    = (ld_req_func3 == F3_LW) || (ld_req_func3 == F3_LBU);
    ld_ok_c    = reset && ld_req_valid && !flush && f3_ok_c && !full_c;
    force_ld_c = ld_ok_c && (streak_q == STK_W'(STORE_STREAK_MAX));
    st_gnt_c   = reset && st_req_valid && !force_ld_c;
    ld_gnt_c   = ld_ok_c && !st_gnt_c;
  end

  // Memory request mux
  always_comb begin
    st_req_ready  = st_gnt_c;
    ld_req_ready  = ld_gnt_c;
    mem_req_valid = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = 32'h0;
    mem_wdata     = 32'h0;
    mem_size      = SZ_BYTE;
    if (st_gnt_c) begin
      mem_req_valid = 1'b1;
      mem_we        = 1'b1;
      mem_addr      = st_req_addr;
      mem_wdata     = st_req_data;
      mem_size      = st_req_sh ? SZ_HALF : SZ_WORD;
    end else if (ld_gnt_c) begin
      mem_req_valid = 1'b1;
      mem_addr      = ld_req_addr;
      mem_size      = (ld_req_func3 == F3_LBU) ? SZ_BYTE : SZ_WORD;
    end
  end

  always_comb begin
    pop_c        = mem_rvalid && (count_q != CNT_W'(0));
    squash_pop_c = fifo_q[rd_ptr_q].squash || flush;
  end

  // Store-streak counter; any idle load cycle or load grant resets it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak_q <= '0;
    end else if (!ld_req_valid || ld_gnt_c) begin
      streak_q <= '0;
    end else if (st_gnt_c && (streak_q != STK_W'(STORE_STREAK_MAX))) begin
      streak_q <= streak_q + STK_W'(1);
    end
  end

  // In-flight tag FIFO; flush marks entries but they still drain with memory data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < MAX_INFLIGHT; i++) begin
        fifo_q[PTR_W'(i)] <= '0;
      end
    end else begin
      if (flush) begin
        for (int unsigned i = 0; i < MAX_INFLIGHT; i++) begin
          fifo_q[PTR_W'(i)].squash <= 1'b1;
        end
      end
      if (ld_gnt_c) begin
        fifo_q[wr_ptr_q] <= tag_t'{rob: ld_req_rob, pd: ld_req_pd, squash: 1'b0};
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({ld_gnt_c, pop_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Load completion and spurious-return flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_resp_valid <= 1'b0;
      ld_resp_data  <= 32'h0;
      ld_resp_pd    <= 7'h0;
      ld_resp_rob   <= 5'h0;
      err_spurious  <= 1'b0;
    end else begin
      ld_resp_valid <= pop_c && !squash_pop_c;
      if (pop_c && !squash_pop_c) begin
        ld_resp_data <= mem_rdata;
        ld_resp_pd   <= fifo_q[rd_ptr_q].pd;
        ld_resp_rob  <= fifo_q[rd_ptr_q].rob;
      end
      if (mem_rvalid && !pop_c) begin
        err_spurious <= 1'b1;
      end
    end
  end

endmodule
